// File: rtl/spi_flash_writer_pkg.sv
// Shared constants for the SPI NOR flash writer: command opcodes, geometry
// and the state encodings of the writer FSM and the command sequencer.
package spi_flash_writer_pkg;

  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_SE   = 8'h20;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] DUMMY    = 8'h00;

  // Status register write-in-progress bit polled after erase/program.
  localparam logic [7:0] WIP_MASK = 8'h01;

  localparam int PAGE_BITS   = 8;
  localparam int SECTOR_BITS = 12;

  typedef logic [3:0] wr_state_t;

  localparam wr_state_t ST_IDLE      = 4'd0;
  localparam wr_state_t ST_CHK       = 4'd1;
  localparam wr_state_t ST_WREN      = 4'd2;
  localparam wr_state_t ST_ERASE     = 4'd3;
  localparam wr_state_t ST_PROG_HDR  = 4'd4;
  localparam wr_state_t ST_FETCH     = 4'd5;
  localparam wr_state_t ST_PROG_DATA = 4'd6;
  localparam wr_state_t ST_PROG_END  = 4'd7;
  localparam wr_state_t ST_POLL_CMD  = 4'd8;
  localparam wr_state_t ST_POLL_RD   = 4'd9;
  localparam wr_state_t ST_GAP       = 4'd10;
  localparam wr_state_t ST_DONE      = 4'd11;

  typedef logic [1:0] sq_state_t;

  localparam sq_state_t SQ_IDLE  = 2'd0;
  localparam sq_state_t SQ_SETUP = 2'd1;
  localparam sq_state_t SQ_WAIT  = 2'd2;
  localparam sq_state_t SQ_HOLD  = 2'd3;

endpackage

// File: rtl/spi_flash_writer_seq.sv
// Byte-at-a-time SPI command sequencer: toggle handshake with the SPI master,
// cs_n framing and the minimum cs_n-high gap between commands.
module spi_cmd_sequencer
  import spi_flash_writer_pkg::*;
#(
  parameter int cs_gap = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_last,
  input  logic       cmd_poll,
  output logic       cmd_done,
  output logic [7:0] rx_byte,
  output logic       cs_n,
  output logic       spi_req,
  input  logic       spi_ack,
  output logic [7:0] spi_d,
  input  logic [7:0] spi_q
);

  // Handshake: a byte (with its last/poll flags) is taken on a cycle with
  // cmd_valid && cmd_ready; cmd_done pulses one cycle when its SPI ack lands,
  // rx_byte valid in that cycle. The owner raises cmd_valid again only after.
  localparam int GW = (cs_gap > 1) ? $clog2(cs_gap) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (cs_gap > 0) ? GW'(cs_gap - 1) : '0;

  sq_state_t     state_q, state_d;
  logic          cs_n_q, cs_n_d;
  logic          spi_req_q, spi_req_d;
  logic [7:0]    spi_d_q, spi_d_d;
  logic          last_q, last_d;
  logic          poll_q, poll_d;
  logic [GW-1:0] gap_q, gap_d;

  always_comb begin
    state_d   = state_q;
    cs_n_d    = cs_n_q;
    spi_req_d = spi_req_q;
    spi_d_d   = spi_d_q;
    last_d    = last_q;
    poll_d    = poll_q;
    gap_d     = gap_q;
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    case (state_q)
      SQ_IDLE: begin
        if (gap_q != '0) gap_d = gap_q - 1'b1;
        cmd_ready = (gap_q == '0);
        if (cmd_valid && gap_q == '0) begin
          spi_d_d = cmd_byte;
          last_d  = cmd_last;
          poll_d  = cmd_poll;
          cs_n_d  = 1'b0;
          state_d = SQ_SETUP;
        end
      end
      SQ_SETUP: begin
        spi_req_d = ~spi_req_q;
        state_d   = SQ_WAIT;
      end
      SQ_HOLD: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          spi_d_d   = cmd_byte;
          last_d    = cmd_last;
          poll_d    = cmd_poll;
          spi_req_d = ~spi_req_q;
          state_d   = SQ_WAIT;
        end
      end
      SQ_WAIT: begin
        if (spi_ack == spi_req_q) begin
          cmd_done = 1'b1;
          // A poll read with WIP clear closes the frame just like a last byte.
          if (last_q || (poll_q && (spi_q & WIP_MASK) == 8'h00)) begin
            cs_n_d  = 1'b1;
            gap_d   = GAP_LOAD;
            state_d = SQ_IDLE;
          end else begin
            state_d = SQ_HOLD;
          end
        end
      end
      default: state_d = SQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SQ_IDLE;
      cs_n_q    <= 1'b1;
      spi_req_q <= spi_ack;
      spi_d_q   <= 8'h00;
      last_q    <= 1'b0;
      poll_q    <= 1'b0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      cs_n_q    <= cs_n_d;
      spi_req_q <= spi_req_d;
      spi_d_q   <= spi_d_d;
      last_q    <= last_d;
      poll_q    <= poll_d;
      gap_q     <= gap_d;
    end
  end

  assign cs_n    = cs_n_q;
  assign spi_req = spi_req_q;
  assign spi_d   = spi_d_q;
  assign rx_byte = spi_q;

endmodule

// File: rtl/spi_flash_writer.sv
// SPI NOR flash programmer: copies bytes from a toggle-handshake source into a
// flash slot using WREN, optional sector erase, page program and RDSR polling.
module spi_flash_writer
  import spi_flash_writer_pkg::*;
#(
  parameter int a_bits = 14,
  parameter int cs_gap = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        slot,
  input  logic              start,
  input  logic              erase_en,
  input  logic [15:0]       start_addr,
  input  logic [19:0]       flash_offset,
  input  logic [15:0]       amount,
  output logic              busy,
  output logic              cs_n,
  output logic              spi_req,
  input  logic              spi_ack,
  output logic [7:0]        spi_d,
  input  logic [7:0]        spi_q,
  output logic              req,
  input  logic              ack,
  output logic [a_bits-1:0] a,
  input  logic [7:0]        q
);

  wr_state_t         state_q, state_d;
  logic [15:0]       idx_q, idx_d, amount_q, amount_d, src_q, src_d;
  logic [23:0]       faddr_q, faddr_d;
  logic              erase_en_q, erase_en_d;
  logic              erase_chunk_q, erase_chunk_d;
  logic              sec_done_q, sec_done_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic              pend_q, pend_d, fetch_q, fetch_d, req_q, req_d;
  logic [a_bits-1:0] a_q, a_d;
  logic [7:0]        data_q, data_d;

  logic        send, cmd_valid, cmd_ready, cmd_last, cmd_poll, cmd_done;
  logic [7:0]  cmd_byte, rx_byte;
  logic        need_erase, data_last;
  logic [23:0] faddr_inc;
  logic [15:0] idx_inc;

  assign faddr_inc  = faddr_q + 24'd1;
  assign idx_inc    = idx_q + 16'd1;
  assign data_last  = (idx_inc == amount_q) || (faddr_inc[PAGE_BITS-1:0] == '0);
  // sec_done_q marks the sector at the current chunk as already erased.
  assign need_erase = erase_en_q && !sec_done_q &&
                      ((idx_q == 16'd0) || (faddr_q[SECTOR_BITS-1:0] == '0));

  always_comb begin
    send     = 1'b1;
    cmd_byte = DUMMY;
    cmd_last = 1'b0;
    cmd_poll = 1'b0;
    case (state_q)
      ST_WREN: begin
        cmd_byte = CMD_WREN;
        cmd_last = 1'b1;
      end
      ST_ERASE: begin
        cmd_last = (bcnt_q == 2'd3);
        case (bcnt_q)
          2'd0:    cmd_byte = CMD_SE;
          2'd1:    cmd_byte = faddr_q[23:16];
          2'd2:    cmd_byte = {faddr_q[15:12], 4'h0};
          default: cmd_byte = 8'h00;
        endcase
      end
      ST_PROG_HDR: begin
        case (bcnt_q)
          2'd0:    cmd_byte = CMD_PP;
          2'd1:    cmd_byte = faddr_q[23:16];
          2'd2:    cmd_byte = faddr_q[15:8];
          default: cmd_byte = faddr_q[7:0];
        endcase
      end
      ST_PROG_DATA: begin
        cmd_byte = data_q;
        cmd_last = data_last;
      end
      ST_POLL_CMD: cmd_byte = CMD_RDSR;
      ST_POLL_RD:  cmd_poll = 1'b1;
      default:     send = 1'b0;
    endcase
  end

  assign cmd_valid = send && !pend_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    amount_d      = amount_q;
    src_d         = src_q;
    faddr_d       = faddr_q;
    erase_en_d    = erase_en_q;
    erase_chunk_d = erase_chunk_q;
    sec_done_d    = sec_done_q;
    bcnt_d        = bcnt_q;
    pend_d        = pend_q;
    fetch_d       = fetch_q;
    req_d         = req_q;
    a_d           = a_q;
    data_d        = data_q;
    if (cmd_valid && cmd_ready) pend_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d         = 16'd0;
          amount_d      = amount;
          src_d         = start_addr;
          faddr_d       = {slot, 20'h00000} + {4'h0, flash_offset};
          erase_en_d    = erase_en;
          erase_chunk_d = 1'b0;
          sec_done_d    = 1'b0;
          bcnt_d        = 2'd0;
          state_d       = (amount == 16'd0) ? ST_DONE : ST_CHK;
        end
      end
      ST_CHK: begin
        erase_chunk_d = need_erase;
        state_d       = ST_WREN;
      end
      ST_FETCH: begin
        if (!fetch_q) begin
          a_d     = src_q[a_bits-1:0];
          req_d   = ~req_q;
          fetch_d = 1'b1;
        end else if (ack == req_q) begin
          data_d  = q;
          fetch_d = 1'b0;
          state_d = ST_PROG_DATA;
        end
      end
      ST_PROG_END: begin
        sec_done_d = 1'b0;
        state_d    = ST_POLL_CMD;
      end
      ST_GAP: begin
        if (erase_chunk_q) begin
          sec_done_d    = 1'b1;
          erase_chunk_d = 1'b0;
          state_d       = ST_CHK;
        end else begin
          state_d = (idx_q == amount_q) ? ST_DONE : ST_CHK;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: ;
    endcase
    if (pend_q && cmd_done) begin
      pend_d = 1'b0;
      case (state_q)
        ST_WREN: begin
          bcnt_d  = 2'd0;
          state_d = erase_chunk_q ? ST_ERASE : ST_PROG_HDR;
        end
        ST_ERASE: begin
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = ST_POLL_CMD;
        end
        ST_PROG_HDR: begin
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = ST_FETCH;
        end
        ST_PROG_DATA: begin
          src_d   = src_q + 16'd1;
          faddr_d = faddr_inc;
          idx_d   = idx_inc;
          state_d = data_last ? ST_PROG_END : ST_FETCH;
        end
        ST_POLL_CMD: state_d = ST_POLL_RD;
        ST_POLL_RD: begin
          if ((rx_byte & WIP_MASK) == 8'h00) state_d = ST_GAP;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= 16'd0;
      amount_q      <= 16'd0;
      src_q         <= 16'd0;
      faddr_q       <= 24'd0;
      erase_en_q    <= 1'b0;
      erase_chunk_q <= 1'b0;
      sec_done_q    <= 1'b0;
      bcnt_q        <= 2'd0;
      pend_q        <= 1'b0;
      fetch_q       <= 1'b0;
      req_q         <= 1'b0;
      a_q           <= '0;
      data_q        <= 8'h00;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      amount_q      <= amount_d;
      src_q         <= src_d;
      faddr_q       <= faddr_d;
      erase_en_q    <= erase_en_d;
      erase_chunk_q <= erase_chunk_d;
      sec_done_q    <= sec_done_d;
      bcnt_q        <= bcnt_d;
      pend_q        <= pend_d;
      fetch_q       <= fetch_d;
      req_q         <= req_d;
      a_q           <= a_d;
      data_q        <= data_d;
    end
  end

  spi_cmd_sequencer #(.cs_gap(cs_gap)) u_seq (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_byte (cmd_byte),
    .cmd_last (cmd_last),
    .cmd_poll (cmd_poll),
    .cmd_done (cmd_done),
    .rx_byte  (rx_byte),
    .cs_n     (cs_n),
    .spi_req  (spi_req),
    .spi_ack  (spi_ack),
    .spi_d    (spi_d),
    .spi_q    (spi_q)
  );

  assign busy = (state_q != ST_IDLE);
  assign req  = req_q;
  assign a    = a_q;

endmodule

// File: tb/tb_spi_flash_writer.sv
// Scoreboard bench for spi_flash_writer: expected SPI frames and source
// addresses are queued per job and checked by a free-running monitor.
module tb_spi_flash_writer;

  localparam int A_BITS = 14;
  localparam int CS_GAP = 4;
  localparam logic [8:0] END_TOK = 9'h100;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [3:0]        slot = '0;
  logic              start = 1'b0;
  logic              erase_en = 1'b0;
  logic [15:0]       start_addr = '0;
  logic [19:0]       flash_offset = '0;
  logic [15:0]       amount = '0;
  logic              busy, cs_n, spi_req, req;
  logic              spi_ack = 1'b0;
  logic [7:0]        spi_d;
  logic [7:0]        spi_q = 8'h00;
  logic              ack = 1'b0;
  logic [A_BITS-1:0] a;
  logic [7:0]        q = 8'h00;

  always #5 clk = ~clk;

  spi_flash_writer #(.a_bits(A_BITS), .cs_gap(CS_GAP)) dut (
    .clk(clk), .reset(reset), .slot(slot), .start(start), .erase_en(erase_en),
    .start_addr(start_addr), .flash_offset(flash_offset), .amount(amount),
    .busy(busy), .cs_n(cs_n), .spi_req(spi_req), .spi_ack(spi_ack),
    .spi_d(spi_d), .spi_q(spi_q), .req(req), .ack(ack), .a(a), .q(q)
  );

  int checks = 0;
  int errors = 0;
  logic [8:0]        exp_q[$];
  logic [A_BITS-1:0] exp_a_q[$];
  logic [7:0]        rdsr_q[$];

  function automatic logic [7:0] src_byte(logic [A_BITS-1:0] x);
    return x[7:0] ^ 8'hA5 ^ {2'b00, x[13:8]};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // SPI flash model: acks after a short delay; RDSR reads pop rdsr_q.
  int spi_dly = 0;
  int frame_pos = 0;
  logic [7:0] frame_cmd = 8'h00;
  always @(negedge clk) begin
    if (reset) begin
      spi_dly = 0;
    end else begin
      if (cs_n) frame_pos = 0;
      if (spi_req != spi_ack) begin
        if (spi_dly < 2) spi_dly++;
        else begin
          spi_dly = 0;
          if (frame_pos == 0) begin
            frame_cmd = spi_d;
            spi_q = 8'h00;
          end else if (frame_cmd == 8'h05 && rdsr_q.size() > 0) spi_q = rdsr_q.pop_front();
          else spi_q = 8'h00;
          frame_pos++;
          spi_ack = spi_req;
        end
      end
    end
  end

  int src_dly = 0;
  always @(negedge clk) begin
    if (reset) begin
      ack = 1'b0;
      src_dly = 0;
    end else if (req != ack) begin
      if (src_dly < 1) src_dly++;
      else begin
        src_dly = 0;
        q = src_byte(a);
        ack = req;
      end
    end
  end

  // Monitor: pops and compares every SPI byte, frame end and source fetch.
  logic prev_cs_n = 1'b1, prev_spi_req = 1'b0, prev_req = 1'b0;
  int gap_len = 0;
  bit gap_track = 1'b0;
  logic [8:0] e;
  logic [A_BITS-1:0] ea;
  always @(negedge clk) begin
    if (!reset) begin
      if (spi_req != prev_spi_req) begin
        check("cs_low_before_xfer", 32'(prev_cs_n), 32'd0);
        if (exp_q.size() == 0) check("unexpected_spi_byte", 32'(spi_d), 32'h1FF);
        else begin
          e = exp_q.pop_front();
          check("spi_byte", {24'd0, spi_d}, {23'd0, e});
        end
      end
      if (cs_n && !prev_cs_n) begin
        if (exp_q.size() == 0) check("unexpected_frame_end", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("frame_end", 32'(END_TOK), {23'd0, e});
        end
        gap_len = 0;
        gap_track = 1'b1;
      end
      if (cs_n) gap_len++;
      if (!cs_n && prev_cs_n && gap_track) check("cs_gap_cycles", 32'(gap_len), 32'(CS_GAP));
      if (req != prev_req) begin
        if (exp_a_q.size() == 0) check("unexpected_src_req", 32'(a), 32'hFFFF);
        else begin
          ea = exp_a_q.pop_front();
          check("src_addr", 32'(a), 32'(ea));
        end
      end
      if (!busy) gap_track = 1'b0;
    end else begin
      gap_track = 1'b0;
    end
    prev_cs_n = cs_n;
    prev_spi_req = spi_req;
    prev_req = req;
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_b(logic [7:0] b);
    exp_q.push_back({1'b0, b});
  endtask

  task automatic push_end();
    exp_q.push_back(END_TOK);
  endtask

  task automatic push_wren();
    push_b(8'h06); push_end();
  endtask

  task automatic push_poll(int busy_reads);
    push_b(8'h05);
    repeat (busy_reads + 1) push_b(8'h00);
    push_end();
  endtask

  task automatic push_erase(logic [7:0] b2, logic [7:0] b1);
    push_wren();
    push_b(8'h20); push_b(b2); push_b(b1); push_b(8'h00); push_end();
    push_poll(0);
  endtask

  // One program chunk: header bytes given by hand, data from source addresses.
  task automatic push_prog(logic [7:0] b2, logic [7:0] b1, logic [7:0] b0,
                           logic [A_BITS-1:0] src, int n);
    logic [A_BITS-1:0] s;
    push_wren();
    push_b(8'h02); push_b(b2); push_b(b1); push_b(b0);
    s = src;
    for (int i = 0; i < n; i++) begin
      push_b(src_byte(s));
      exp_a_q.push_back(s);
      s = s + 1'b1;
    end
    push_end();
  endtask

  task automatic start_job(logic [3:0] s, logic [19:0] off, logic [15:0] sa,
                           logic [15:0] amt, logic en);
    slot = s; flash_offset = off; start_addr = sa; amount = amt; erase_en = en;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    while (busy && n < 4000) begin
      cyc(1);
      n++;
    end
    check({name, "_done_in_budget"}, 32'(busy), 32'd0);
    cyc(8);
    check({name, "_frames_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_fetches_left"}, 32'(exp_a_q.size()), 32'd0);
    exp_q.delete();
    exp_a_q.delete();
    rdsr_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int busy_cycles, changes, n;
    logic cs0, sr0, r0;
    reset = 1'b1;
    cyc(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_spi_d", 32'(spi_d), 32'd0);
    check("rst_req", 32'(req), 32'd0);
    check("rst_a", 32'(a), 32'd0);
    check("rst_spi_req_eq_ack", 32'(spi_req ^ spi_ack), 32'd0);
    reset = 1'b0;
    cyc(2);

    // Basic: slot 2, offset 0x100 -> flash 0x200100; a wraps to 0x0000.
    push_prog(8'h20, 8'h01, 8'h00, 14'h0000, 4);
    push_poll(0);
    start_job(4'h2, 20'h00100, 16'h8000, 16'd4, 1'b0);
    check("basic_busy_after_start", 32'(busy), 32'd1);
    cyc(20);
    start_job(4'hF, 20'h12345, 16'h1111, 16'h0055, 1'b1);
    wait_idle("basic");

    // Page split at 0x0FF/0x100.
    push_prog(8'h00, 8'h00, 8'hFE, 14'h0010, 2);
    push_poll(0);
    push_prog(8'h00, 8'h01, 8'h00, 14'h0012, 2);
    push_poll(0);
    start_job(4'h0, 20'h000FE, 16'h0010, 16'd4, 1'b0);
    wait_idle("page_split");

    // Erase across sector 0 -> 1.
    push_erase(8'h00, 8'h00);
    push_prog(8'h00, 8'h0F, 8'hFF, 14'h0100, 1);
    push_poll(0);
    push_erase(8'h00, 8'h10);
    push_prog(8'h00, 8'h10, 8'h00, 14'h0101, 1);
    push_poll(0);
    start_job(4'h0, 20'h00FFF, 16'h0100, 16'd2, 1'b1);
    wait_idle("erase_sector");

    // Poll loop: status 03, 03, 00 -> three dummy reads in one frame.
    rdsr_q.push_back(8'h03); rdsr_q.push_back(8'h03); rdsr_q.push_back(8'h00);
    push_prog(8'h00, 8'h00, 8'hFF, 14'h0200, 1);
    push_poll(2);
    push_prog(8'h00, 8'h01, 8'h00, 14'h0201, 1);
    push_poll(0);
    start_job(4'h0, 20'h000FF, 16'h0200, 16'd2, 1'b0);
    wait_idle("poll_loop");
    check("poll_status_consumed", 32'(rdsr_q.size()), 32'd0);

    // Zero length: one busy cycle, no bus activity.
    cs0 = cs_n; sr0 = spi_req; r0 = req;
    busy_cycles = 0;
    changes = 0;
    start_job(4'h3, 20'h00000, 16'h0000, 16'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (busy) busy_cycles++;
      if (cs_n !== cs0 || spi_req !== sr0 || req !== r0) changes++;
      cyc(1);
    end
    check("zero_len_busy_cycles", 32'(busy_cycles), 32'd1);
    check("zero_len_bus_changes", 32'(changes), 32'd0);

    // Reset while a data byte is in flight.
    push_prog(8'h00, 8'h00, 8'h40, 14'h0000, 8);
    push_poll(0);
    start_job(4'h0, 20'h00040, 16'h0000, 16'd8, 1'b0);
    n = 0;
    while (exp_q.size() > 10 && n < 2000) begin
      cyc(1);
      n++;
    end
    check("reached_prog_data", 32'(exp_q.size() <= 10), 32'd1);
    reset = 1'b1;
    cyc(1);
    check("midrst_cs_n", 32'(cs_n), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_spi_req_eq_ack", 32'(spi_req ^ spi_ack), 32'd0);
    check("midrst_req", 32'(req), 32'd0);
    exp_q.delete();
    exp_a_q.delete();
    rdsr_q.delete();
    cyc(1);
    reset = 1'b0;
    cyc(2);

    // Clean job after reset; slot 1, source address wraps 0x3FFF -> 0x0000.
    push_prog(8'h10, 8'h00, 8'h10, 14'h3FFE, 3);
    push_poll(0);
    start_job(4'h1, 20'h00010, 16'h3FFE, 16'd3, 1'b0);
    wait_idle("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
